// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD up/down timer with a cycle prescaler and IDLE/RUN/PAUSE/DONE control.
// Commands are prioritised clear > load > stop > start; all outputs are registered.
module bcd_timer_ctrl #(
  parameter logic [15:0] PRESCALE = 16'd1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       up_down,
  input  logic       wrap_en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [15:0] LAST = PRESCALE - 16'd1;

  state_t      r_state;
  logic [15:0] r_presc;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic        r_running;
  logic        r_done;
  logic        r_tick;
  logic        r_wrap;

  logic        w_presc_last;
  logic        w_at_term;
  logic [3:0]  w_step_tens;
  logic [3:0]  w_step_ones;
  logic [3:0]  w_wrap_digit;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_presc_last = (r_presc == LAST);
  assign w_at_term    = up_down ? (r_tens == 4'd9 && r_ones == 4'd9)
                                : (r_tens == 4'd0 && r_ones == 4'd0);
  // Wrap lands on 00 going up and 99 going down.
  assign w_wrap_digit = up_down ? 4'd0 : 4'd9;

  always_comb begin
    w_step_tens = r_tens;
    w_step_ones = r_ones;
    if (up_down) begin
      if (r_ones == 4'd9) begin
        w_step_ones = 4'd0;
        w_step_tens = r_tens + 4'd1;
      end else begin
        w_step_ones = r_ones + 4'd1;
      end
    end else begin
      if (r_ones == 4'd0) begin
        w_step_ones = 4'd9;
        w_step_tens = r_tens - 4'd1;
      end else begin
        w_step_ones = r_ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_presc   <= 16'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (clear) begin
        r_state   <= S_IDLE;
        r_presc   <= 16'd0;
        r_tens    <= 4'd0;
        r_ones    <= 4'd0;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else if (load) begin
        r_state   <= S_IDLE;
        r_presc   <= 16'd0;
        r_tens    <= sat9(load_tens);
        r_ones    <= sat9(load_ones);
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!stop && start) begin
              r_state   <= S_RUN;
              r_presc   <= 16'd0;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            // A stop wins over a pending step: prescaler and digits freeze as-is.
            if (stop) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end else if (w_presc_last) begin
              r_presc <= 16'd0;
              if (!w_at_term) begin
                r_tens <= w_step_tens;
                r_ones <= w_step_ones;
                r_tick <= 1'b1;
              end else if (wrap_en) begin
                r_tens <= w_wrap_digit;
                r_ones <= w_wrap_digit;
                r_tick <= 1'b1;
                r_wrap <= 1'b1;
              end else begin
                r_state   <= S_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + 16'd1;
            end
          end
          S_PAUSE: begin
            if (!stop && start) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign running = r_running;
  assign done    = r_done;
  assign tick    = r_tick;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl: one PRESCALE=3 and one PRESCALE=1 instance
// share the same stimulus; each scenario checks the instance it targets.
module tb_bcd_timer_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       up_down = 1'b1;
  logic       wrap_en = 1'b0;

  logic [3:0] a_tens, a_ones, b_tens, b_ones;
  logic       a_running, a_done, a_tick, a_wrap;
  logic       b_running, b_done, b_tick, b_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(.PRESCALE(16'd3)) u_p3 (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .up_down(up_down), .wrap_en(wrap_en),
    .tens(a_tens), .ones(a_ones), .running(a_running), .done(a_done),
    .tick(a_tick), .wrap(a_wrap)
  );

  bcd_timer_ctrl #(.PRESCALE(16'd1)) u_p1 (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_tens(load_tens), .load_ones(load_ones),
    .up_down(up_down), .wrap_en(wrap_en),
    .tens(b_tens), .ones(b_ones), .running(b_running), .done(b_done),
    .tick(b_tick), .wrap(b_wrap)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; clear = 0; load = 0;
    resetn = 0;
    edge1();
    resetn = 1;
  endtask

  initial begin
    // ---- Reset state (asynchronous, before any clock edge)
    #1;
    check_val("rst_tens", a_tens, 0);
    check_val("rst_ones", a_ones, 0);
    check_val("rst_running", a_running, 0);
    check_val("rst_done", a_done, 0);
    check_val("rst_tick", a_tick, 0);
    check_val("rst_wrap", a_wrap, 0);

    // ---- PRESCALE=3 up count: a step every third RUN cycle, 10 after 30
    do_reset();
    up_down = 1; wrap_en = 0;
    start = 1;
    edge1();
    start = 0;
    check_val("p3_run_entry", a_running, 1);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      edge1();
      check_val($sformatf("p3_tick_c%0d", cyc), a_tick, (cyc % 3 == 0) ? 1 : 0);
      if (cyc == 3) check_val("p3_ones_c3", a_ones, 1);
      if (cyc == 2) check_val("p3_ones_c2", a_ones, 0);
    end
    check_val("p3_tens_c30", a_tens, 1);
    check_val("p3_ones_c30", a_ones, 0);

    // ---- PRESCALE=1 load 98, up, no wrap -> 99 then DONE, start ignored
    do_reset();
    load = 1; load_tens = 4'd9; load_ones = 4'd8; up_down = 1; wrap_en = 0;
    edge1();
    load = 0; start = 1;
    check_val("p1_load98_ones", b_ones, 8);
    edge1();
    check_val("p1_run_entry", b_running, 1);
    edge1();
    check_val("p1_step99_tens", b_tens, 9);
    check_val("p1_step99_ones", b_ones, 9);
    check_val("p1_step99_tick", b_tick, 1);
    edge1();
    check_val("p1_done", b_done, 1);
    check_val("p1_done_running", b_running, 0);
    check_val("p1_done_tick", b_tick, 0);
    edge1();
    edge1();
    check_val("p1_done_hold", b_done, 1);
    check_val("p1_done_hold_tens", b_tens, 9);
    check_val("p1_done_hold_ones", b_ones, 9);
    start = 0;

    // ---- PRESCALE=1 load 00, down, wrap -> 99 with wrap, then 98
    do_reset();
    load = 1; load_tens = 4'd0; load_ones = 4'd0; up_down = 0; wrap_en = 1;
    edge1();
    load = 0; start = 1;
    edge1();
    start = 0;
    edge1();
    check_val("p1_wrap_tens", b_tens, 9);
    check_val("p1_wrap_ones", b_ones, 9);
    check_val("p1_wrap_pulse", b_wrap, 1);
    check_val("p1_wrap_tick", b_tick, 1);
    check_val("p1_wrap_running", b_running, 1);
    edge1();
    check_val("p1_after_wrap_ones", b_ones, 8);
    check_val("p1_after_wrap_wrap", b_wrap, 0);
    check_val("p1_after_wrap_tick", b_tick, 1);

    // ---- PRESCALE=3 pause at prescaler=1, resume keeps partial period
    do_reset();
    up_down = 1; wrap_en = 0;
    start = 1;
    edge1();
    start = 0;
    edge1();
    stop = 1;
    edge1();
    stop = 0;
    check_val("p3_pause_running", a_running, 0);
    for (int k = 0; k < 5; k++) begin
      edge1();
      check_val($sformatf("p3_pause_ones_%0d", k), a_ones, 0);
      check_val($sformatf("p3_pause_tick_%0d", k), a_tick, 0);
    end
    start = 1;
    edge1();
    start = 0;
    check_val("p3_resume_running", a_running, 1);
    edge1();
    check_val("p3_resume_c1_ones", a_ones, 0);
    edge1();
    check_val("p3_resume_c2_ones", a_ones, 1);
    check_val("p3_resume_c2_tick", a_tick, 1);

    // ---- PRESCALE=1 clear+load+start at 57 in RUN, then saturating load
    do_reset();
    load = 1; load_tens = 4'd5; load_ones = 4'd6; up_down = 1; wrap_en = 0;
    edge1();
    load = 0; start = 1;
    edge1();
    edge1();
    check_val("p1_at57_tens", b_tens, 5);
    check_val("p1_at57_ones", b_ones, 7);
    clear = 1; load = 1; load_tens = 4'hC; load_ones = 4'hF;
    edge1();
    clear = 0; start = 0;
    check_val("p1_clear_tens", b_tens, 0);
    check_val("p1_clear_ones", b_ones, 0);
    check_val("p1_clear_running", b_running, 0);
    check_val("p1_clear_tick", b_tick, 0);
    edge1();
    load = 0;
    check_val("p1_sat_tens", b_tens, 9);
    check_val("p1_sat_ones", b_ones, 9);
    check_val("p1_sat_running", b_running, 0);

    // ---- PRESCALE=3 async reset mid-RUN at 42, then stays IDLE
    do_reset();
    load = 1; load_tens = 4'd4; load_ones = 4'd2;
    edge1();
    load = 0; start = 1;
    edge1();
    start = 0;
    check_val("p3_at42_running", a_running, 1);
    check_val("p3_at42_tens", a_tens, 4);
    #3 resetn = 0;
    #1;
    check_val("p3_async_tens", a_tens, 0);
    check_val("p3_async_ones", a_ones, 0);
    check_val("p3_async_running", a_running, 0);
    edge1();
    resetn = 1;
    for (int k = 0; k < 4; k++) edge1();
    check_val("p3_postrst_running", a_running, 0);
    check_val("p3_postrst_ones", a_ones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter PRESCALE, default 16'd1000, clock cycles per count step; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin/resume counting (level sampled each cycle).
REQ-005 stop  input  1  pause counting.
REQ-006 clear  input  1  force digits to 00 and return to IDLE.
REQ-007 load  input  1  preset digits from load_tens/load_ones and return to IDLE.
REQ-008 load_tens, load_ones  input  4 each  BCD preset values.
REQ-009 up_down  input  1  1 = count up, 0 = count down; sampled at each step.
REQ-010 wrap_en  input  1  1 = wrap at terminal value, 0 = stop in DONE.
REQ-011 tens, ones  output  4 each  current BCD digits, registered.
REQ-012 running  output  1  high while in RUN.
REQ-013 done  output  1  high while in DONE.
REQ-014 tick  output  1  one-cycle pulse, cycle after each digit step.
REQ-015 wrap  output  1  one-cycle pulse, cycle after each wrap step (coincides with tick).

Function
REQ-016 States IDLE, RUN, PAUSE, DONE; encoding free; running and done decode from state, registered.
REQ-017 Command priority per cycle: clear > load > stop > start; lower-priority commands are ignored that cycle.
REQ-018 clear, any state: next state IDLE, digits 00, prescaler 0, no tick/wrap.
REQ-019 load, any state: next state IDLE, prescaler 0; each preset digit >9 saturates to 9.
REQ-020 IDLE + start -> RUN, prescaler restarts at 0.
REQ-021 RUN + stop -> PAUSE; prescaler and digits hold; no step on that edge even if prescaler is at PRESCALE-1.
REQ-022 PAUSE + start -> RUN; prescaler resumes from held value (no lost partial period).
REQ-023 DONE: start and stop ignored; only clear, load or reset leave DONE.
REQ-024 Prescaler counts 0..PRESCALE-1 only in RUN; at PRESCALE-1 it returns to 0 and one digit step occurs on that edge; PRESCALE=1 steps every RUN cycle.
REQ-025 Up step: ones 0-8 increments; ones 9 -> 0 with tens incremented; terminal 99.
REQ-026 Down step: ones 1-9 decrements; ones 0 -> 9 with tens decremented; terminal 00.
REQ-027 Step from terminal (99 up / 00 down): wrap_en=1 -> digits become 00 (up) or 99 (down), stay RUN, pulse wrap; wrap_en=0 -> digits hold, go DONE, no tick.
REQ-028 Digits never leave BCD range 0-9 under any input sequence.
REQ-029 tick and wrap are registered, high exactly one cycle after the stepping edge, low otherwise.
REQ-030 up_down change between steps takes effect at the next step; no effect on state.

Reset
REQ-031 resetn low: immediately state IDLE, tens=0, ones=0, prescaler=0, running=0, done=0, tick=0, wrap=0, independent of clk.
REQ-032 resetn deassertion mid-RUN: block restarts from IDLE; start required to resume.

Verification
REQ-033 PRESCALE=3, reset, start 1 cycle, up -> digits 01 three cycles after RUN entry, tick each third cycle, 10 after 30 cycles.
REQ-034 PRESCALE=1, load 98, start, up, wrap_en=0 -> 99 next step, then DONE, done=1, digits hold 99, start ignored.
REQ-035 PRESCALE=1, load 00, start, down, wrap_en=1 -> step to 99 with wrap+tick pulsed once, running stays 1, next 98.
REQ-036 PRESCALE=3, RUN, stop at prescaler=1, hold 5 cycles, start -> next step 2 RUN cycles later, digits unchanged during PAUSE.
REQ-037 Same cycle clear+load+start in RUN at 57 -> IDLE, digits 00; load of tens=C, ones=F -> digits 99.
REQ-038 resetn pulsed low between clock edges during RUN at 42 -> outputs 00/IDLE before next edge.
